matrix_h_fetch_ctrl: RTL and testbench
======================================

Name: matrix_h_fetch_ctrl

Overview:
- Sequencer that reads the 4x4 complex channel matrix H out of the two Matrix_H ROM instances: row 0 holds the real parts, row 1 the imaginary parts, and both share one column address.
- Emits the 16 complex entries as a valid/ready stream, in either row-major order (H) or column-major order (H^T), for the downstream MIMO detector.
- Owns the ROM address bus and absorbs the 1-cycle ROM read latency under backpressure, using a 2-entry output buffer.

Parameters:
- DIM, 4: matrix dimension. Entries per matrix = DIM*DIM. Must be a power of 2.
- DATA_W, 16: width of each real and imaginary sample.
- ADDR_W, 2*$clog2(DIM): ROM address width. Derived; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one matrix read. Sampled only in IDLE.
- transpose  in  1  order select, latched at start. 0 = row-major, 1 = column-major.
- conj  in  1  conjugate select, latched at start. Used only with MATRIX_H_CONJ_EN.
- rom_addr  out  ADDR_W  column address driven to both Matrix_H instances.
- rom_real  in  DATA_W  signed real data from the row-0 ROM, valid 1 cycle after rom_addr.
- rom_im  in  DATA_W  signed imaginary data from the row-1 ROM, valid 1 cycle after rom_addr.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream ready.
- out_real  out  DATA_W  entry real part.
- out_im  out  DATA_W  entry imaginary part.
- out_row  out  $clog2(DIM)  matrix row index of the emitted entry.
- out_col  out  $clog2(DIM)  matrix column index of the emitted entry.
- out_last  out  1  high on the final (16th) entry.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM goes to IDLE; issue counter and both buffer entries are cleared.
  - rom_addr=0, out_valid=0, out_real=0, out_im=0, out_row=0, out_col=0, out_last=0, busy=0, done=0.
  - Reset mid-read aborts immediately; no done pulse is produced.
- FSM states:
  - IDLE: on start=1, latch transpose and conj, clear the issue counter k, go to FETCH.
  - FETCH: issue ROM reads. When k reaches DIM*DIM, go to DRAIN.
  - DRAIN: wait until every in-flight and buffered entry has been handed off, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in FETCH and DRAIN. busy=0 in IDLE and DONE.
- start is ignored in every state except IDLE, including the DONE cycle.
- Address generation, with k = 0..15 and k = {kh,kl} (2 bits each):
  - transpose=0: rom_addr = k.
  - transpose=1: rom_addr = {kl,kh}.
  - The emitted entry carries out_row = rom_addr[3:2] and out_col = rom_addr[1:0] of the address that produced it.
- Issue rule:
  - A read issues in a cycle when the state is FETCH and (buffered entries + in-flight reads) < 2 after accounting for a handshake in the same cycle.
  - In-flight reads are at most 1.
  - When a read issues, rom_addr takes the new address; the returned data is captured on the next edge into the buffer, tagged with row, col and last.
- Buffer:
  - 2-entry FIFO. The head drives the out_* ports.
  - out_valid = head occupied.
  - Handshake occurs when out_valid && out_ready.
  - Outputs must stay stable while out_valid=1 and out_ready=0.
- Throughput: with out_ready held at 1, one entry per cycle.
  - First out_valid appears 2 cycles after the start edge: FETCH entry, then the ROM latency.
  - The 16th handshake happens 17 cycles after start. done is high in the cycle after it.
- Simultaneous events:
  - A capture and a handshake in the same cycle keep occupancy unchanged.
  - With the buffer full and out_ready=0, no issue occurs. rom_addr holds its last value; ROM data is ignored because nothing is in flight.
- out_last is high only on the entry with k=15. It drops once that entry is accepted.

Optional Feature:
- Macro MATRIX_H_CONJ_EN.
- Defined: when the latched conj=1, out_im = -rom_im computed at capture, saturating so that -32768 maps to 32767. The result yields H^H when combined with transpose=1. When the latched conj=0, values pass through unchanged.
- Not defined: the conj port still exists but is ignored; out_im always equals rom_im.

Test Plan:
- Bench ROM model: real=0x0100+addr, im=0x0200+addr. Pulse start with transpose=0 and out_ready=1.
  -> 16 entries on consecutive cycles, with out_real 0x0100..0x010F in order.
  -> out_row/out_col step (0,0),(0,1)..(3,3).
  -> out_last on the 16th entry; done 1 cycle later; busy low afterwards.
- transpose=1, out_ready=1.
  -> out_real sequence 0x0100,0x0104,0x0108,0x010C,0x0101,..,0x010F.
  -> out_row/out_col step (0,0),(1,0),(2,0),(3,0),(0,1)..
- transpose=0, out_ready toggling 1,0,0,1,...
  -> No entry lost or duplicated; data stable while stalled.
  -> Never more than 2 entries buffered; all 16 entries in order.
- Assert rst for one cycle after the 7th handshake.
  -> Next cycle: out_valid=0, busy=0, no done pulse.
  -> A new start afterwards produces a full 16-entry read from address 0.
- Pulse start again while busy.
  -> Ignored: exactly 16 entries and one done pulse.
- With MATRIX_H_CONJ_EN and conj=1, ROM im at addr 5 = 0x8000 and at addr 6 = 0x0003.
  -> Those entries emit out_im=0x7FFF and 0xFFFD.
  -> Same stimulus without the macro emits 0x8000 and 0x0003.

Source files
------------

// File: rtl/matrix_h_fetch_ctrl.sv
// Streams the 4x4 complex channel matrix H (or H^T) out of the two Matrix_H ROMs.
// Optional conjugation of the imaginary part is enabled by defining MATRIX_H_CONJ_EN.
module matrix_h_fetch_ctrl #(
  parameter  int unsigned DIM    = 4,
  parameter  int unsigned DATA_W = 16,
  localparam int unsigned IDX_W  = $clog2(DIM),
  localparam int unsigned ADDR_W = 2 * IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              transpose,
  input  logic              conj,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_real,
  input  logic [DATA_W-1:0] rom_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_im,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ENTRIES = DIM * DIM;
  localparam int unsigned K_W     = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              last;
  } entry_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              tr_q, tr_d;
  logic              conj_q, conj_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              inflight_q, inflight_d;
  logic              last_inflight_q, last_inflight_d;
  logic [1:0]        cnt_q, cnt_d;
  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs_c;
  logic [1:0]        base_occ_c;
  logic [ADDR_W-1:0] k_low_c;
  logic [ADDR_W-1:0] addr_k_c;
  logic [DATA_W-1:0] cap_im_c;
  entry_t            cap_entry_c;

  // Imaginary part as stored in the buffer: optionally negated with saturation.
`ifdef MATRIX_H_CONJ_EN
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  always_comb begin
    cap_im_c = rom_im;
    if (conj_q) begin
      if (rom_im == MIN_NEG) cap_im_c = ~MIN_NEG;
      else                   cap_im_c = DATA_W'(-rom_im);
    end
  end
`else
  logic unused_conj;
  assign unused_conj = conj_q;
  assign cap_im_c    = rom_im;
`endif

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    tr_d            = tr_q;
    conj_d          = conj_q;
    rom_addr_d      = rom_addr_q;
    inflight_d      = 1'b0;
    last_inflight_d = 1'b0;
    head_d          = head_q;
    tail_d          = tail_q;

    hs_c       = valid_q && out_ready;
    base_occ_c = cnt_q - 2'(hs_c);
    k_low_c    = k_q[ADDR_W-1:0];
    addr_k_c   = tr_q ? {k_low_c[IDX_W-1:0], k_low_c[ADDR_W-1:IDX_W]} : k_low_c;

    cap_entry_c.re   = rom_real;
    cap_entry_c.im   = cap_im_c;
    cap_entry_c.row  = rom_addr_q[ADDR_W-1:IDX_W];
    cap_entry_c.col  = rom_addr_q[IDX_W-1:0];
    cap_entry_c.last = last_inflight_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          tr_d    = transpose;
          conj_d  = conj;
          k_d     = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Occupancy after this cycle's capture and handshake must leave room.
        if ((3'(base_occ_c) + 3'(inflight_q)) < 3'd2) begin
          rom_addr_d      = addr_k_c;
          inflight_d      = 1'b1;
          last_inflight_d = (k_q == K_W'(ENTRIES - 1));
          k_d             = k_q + K_W'(1);
          if (k_q == K_W'(ENTRIES - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((base_occ_c == 2'd0) && !inflight_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Two-entry FIFO: pop shifts the tail forward, capture fills the first free slot.
    if (hs_c) begin
      head_d = tail_q;
      tail_d = '0;
    end
    if (inflight_q) begin
      if (base_occ_c == 2'd0) head_d = cap_entry_c;
      else                    tail_d = cap_entry_c;
    end
    cnt_d   = base_occ_c + 2'(inflight_q);
    valid_d = (cnt_d != 2'd0);
    busy_d  = (state_d == FETCH) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      k_q             <= '0;
      tr_q            <= 1'b0;
      conj_q          <= 1'b0;
      rom_addr_q      <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      cnt_q           <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      valid_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      tr_q            <= tr_d;
      conj_q          <= conj_d;
      rom_addr_q      <= rom_addr_d;
      inflight_q      <= inflight_d;
      last_inflight_q <= last_inflight_d;
      cnt_q           <= cnt_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      valid_q         <= valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_valid = valid_q;
  assign out_real  = head_q.re;
  assign out_im    = head_q.im;
  assign out_row   = head_q.row;
  assign out_col   = head_q.col;
  assign out_last  = head_q.last;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_h_fetch_ctrl.sv
// Directed bench for matrix_h_fetch_ctrl: ROM model, scoreboard queue of expected entries,
// checks on ordering, timing, stall stability, reset abort, ignored restart and conjugation.
module tb_matrix_h_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        transpose;
  logic        conj;
  logic [3:0]  rom_addr;
  logic [15:0] rom_real;
  logic [15:0] rom_im;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_real;
  logic [15:0] out_im;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] rom_im_mem [16];
  logic [36:0] sb [$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign rom_real = 16'h0100 + 16'(rom_addr);
  assign rom_im   = rom_im_mem[rom_addr];

  matrix_h_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .transpose (transpose),
    .conj      (conj),
    .rom_addr  (rom_addr),
    .rom_real  (rom_real),
    .rom_im    (rom_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_im    (out_im),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {real, im, row, col, last} for the idx-th emitted entry.
  function automatic logic [36:0] exp_entry(input int idx, input bit tr, input bit cj);
    logic [3:0]  k;
    logic [3:0]  a;
    logic [15:0] re;
    logic [15:0] im;
    logic        lst;
    k   = 4'(idx);
    a   = tr ? {k[1:0], k[3:2]} : k;
    re  = 16'h0100 + 16'(a);
    im  = rom_im_mem[a];
    lst = (idx == 15);
`ifdef MATRIX_H_CONJ_EN
    if (cj) im = (im == 16'h8000) ? 16'h7FFF : 16'(~im + 16'd1);
`else
    lst = lst | (cj & 1'b0);
`endif
    return {re, im, a[3:2], a[1:0], lst};
  endfunction

  // One matrix read; cycle 0 is the cycle right after the start edge.
  task automatic run_read(input bit tr, input bit cj, input bit toggle, input int rst_at,
                          input bit restart, output int first_valid, output int last_hs,
                          output int done_cyc, output int n_hs, output int n_done);
    logic [36:0] held;
    logic [36:0] obs;
    logic [36:0] exp;
    bit          stall;
    int          rst_cyc;
    first_valid = -1; last_hs = -1; done_cyc = -1; n_hs = 0; n_done = 0;
    stall = 1'b0; rst_cyc = -1; held = '0;
    @(negedge clk);
    transpose = tr; conj = cj; start = 1'b1;
    for (int i = 0; i < 16; i++) sb.push_back(exp_entry(i, tr, cj));
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start     = restart && (c == 5);
      transpose = ~tr;
      conj      = ~cj;
      obs = {out_real, out_im, out_row, out_col, out_last};
      if (c == 0) check("busy_after_start", 64'(busy), 64'd1);
      if (stall) check("stall_hold", 64'(obs), 64'(held));
      out_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (rst_cyc >= 0 && c == rst_cyc + 1) rst = 1'b1;
      if (rst_cyc >= 0 && c == rst_cyc + 2) begin
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
      end
      if (rst_cyc >= 0 && c >= rst_cyc + 2) check("rst_no_done", 64'(done), 64'd0);
      if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (out_valid === 1'b1 && out_ready && !(rst_cyc >= 0 && c > rst_cyc)) begin
        check("sb_nonempty_at_hs", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check($sformatf("entry%0d", n_hs), 64'(obs), 64'(exp));
        end
        n_hs++;
        last_hs = c;
        if (n_hs == rst_at) rst_cyc = c;
      end
      if (done === 1'b1) begin
        n_done++;
        done_cyc = c;
      end
      stall = (out_valid === 1'b1) && !out_ready;
      held  = obs;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      if (rst_cyc >= 0 && c >= rst_cyc + 6) break;
    end
    start = 1'b0; rst = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    int fv, lh, dc, nh, nd;
    for (int a = 0; a < 16; a++) rom_im_mem[a] = 16'h0200 + 16'(a);
    rst = 1'b1; start = 1'b0; transpose = 1'b0; conj = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'({out_real, out_im}), 64'd0);
    check("rst_out_rowcol", 64'({out_row, out_col, out_last}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Row-major, always ready: timing and order.
    run_read(1'b0, 1'b0, 1'b0, -1, 1'b0, fv, lh, dc, nh, nd);
    check("rm_first_valid_cyc", 64'(fv), 64'd2);
    check("rm_last_hs_cyc", 64'(lh), 64'd17);
    check("rm_done_cyc", 64'(dc), 64'd18);
    check("rm_n_hs", 64'(nh), 64'd16);
    check("rm_n_done", 64'(nd), 64'd1);
    check("rm_busy_after", 64'(busy), 64'd0);

    // Column-major.
    run_read(1'b1, 1'b0, 1'b0, -1, 1'b0, fv, lh, dc, nh, nd);
    check("cm_last_hs_cyc", 64'(lh), 64'd17);
    check("cm_n_hs", 64'(nh), 64'd16);
    check("cm_n_done", 64'(nd), 64'd1);

    // Backpressure pattern 1,0,0,1.
    run_read(1'b0, 1'b0, 1'b1, -1, 1'b0, fv, lh, dc, nh, nd);
    check("bp_n_hs", 64'(nh), 64'd16);
    check("bp_n_done", 64'(nd), 64'd1);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Reset after the 7th handshake aborts the read.
    run_read(1'b0, 1'b0, 1'b0, 7, 1'b0, fv, lh, dc, nh, nd);
    check("abort_n_hs", 64'(nh), 64'd7);
    check("abort_n_done", 64'(nd), 64'd0);
    check("abort_sb_left", 64'(sb.size()), 64'd9);
    sb.delete();
    run_read(1'b0, 1'b0, 1'b0, -1, 1'b0, fv, lh, dc, nh, nd);
    check("post_abort_n_hs", 64'(nh), 64'd16);
    check("post_abort_n_done", 64'(nd), 64'd1);

    // Start pulsed again while busy is ignored.
    run_read(1'b1, 1'b0, 1'b0, -1, 1'b1, fv, lh, dc, nh, nd);
    check("restart_n_hs", 64'(nh), 64'd16);
    check("restart_n_done", 64'(nd), 64'd1);
    repeat (20) @(negedge clk);
    check("restart_no_valid", 64'(out_valid), 64'd0);
    check("restart_idle", 64'(busy), 64'd0);

    // Conjugate request with saturation corner.
    rom_im_mem[5] = 16'h8000;
    rom_im_mem[6] = 16'h0003;
    run_read(1'b0, 1'b1, 1'b0, -1, 1'b0, fv, lh, dc, nh, nd);
    check("conj_n_hs", 64'(nh), 64'd16);
    check("conj_n_done", 64'(nd), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
